ifm_feed_ctrl: RTL and testbench

Sequencer that feeds the convolution engine's input-feature-map slice path from the wide AXI-Stream IFM input. It accepts a programmed number of INPUT_WIDTH-bit beats after each convolution start and buffers them in a two-entry word FIFO. It issues them to the PE array as OUTPUT_WIDTH-bit slices under a valid/ready handshake, then reports completion. It replaces free-running slice counting with a length-bounded, back-pressured, restartable controller.

---
 rtl/ifm_feed_ctrl.sv | 122 ++++++++++++
 tb/tb_ifm_feed_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_feed_ctrl.sv
// ifm_feed_ctrl: length-bounded feeder that splits AXIS IFM beats into LSB-first slices through a 2-entry FIFO.
// Start->tready in 1 cycle, accept->fm_valid in 1 cycle; fm_ready low stalls slices, fills the FIFO and drops tready. Optional tlast checking is enabled by IFM_FEED_TLAST_CHECK_EN.
module ifm_feed_ctrl #(
  parameter int INPUT_WIDTH  = 512,
  parameter int OUTPUT_WIDTH = 64,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conv_start,
  input  logic [LEN_WIDTH-1:0]    num_words,
  input  logic [INPUT_WIDTH-1:0]  s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [OUTPUT_WIDTH-1:0] fm_out,
  output logic                    fm_valid,
  input  logic                    fm_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err_tlast
);

  localparam int SLICES = INPUT_WIDTH / OUTPUT_WIDTH;
  localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [SW-1:0]        SLICE_LAST = SW'(SLICES - 1);
  localparam logic [SW-1:0]        SLICE_ONE  = SW'(1);
  localparam logic [LEN_WIDTH-1:0] ONE        = LEN_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [LEN_WIDTH-1:0] len, acc_cnt, pop_cnt;
  logic [SW-1:0]        slice_cnt;
  logic [INPUT_WIDTH-1:0] mem [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count;
  logic                 full, empty, start_ok, push, slice_take, pop, last_take;
  logic [SLICES-1:0][OUTPUT_WIDTH-1:0] head;

  assign full          = (count == 2'd2);
  assign empty         = (count == 2'd0);
  assign start_ok      = (state == IDLE) && conv_start;
  assign s_axis_tready = (state == RUN) && (acc_cnt < len) && !full;
  assign push          = s_axis_tready && s_axis_tvalid;
  assign fm_valid      = (state == RUN) && !empty;
  assign head          = mem[rd_ptr];
  assign fm_out        = head[slice_cnt];
  assign slice_take    = fm_valid && fm_ready;
  assign pop           = slice_take && (slice_cnt == SLICE_LAST);
  assign last_take     = pop && (pop_cnt == len - ONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (conv_start) state_nxt = (num_words != '0) ? RUN : DONE;
      RUN:  if (last_take)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Full is judged before the pop, so a same-cycle push never lands on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= '0;
      acc_cnt   <= '0;
      pop_cnt   <= '0;
      slice_cnt <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else if (start_ok) begin
      len       <= num_words;
      acc_cnt   <= '0;
      pop_cnt   <= '0;
      slice_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_axis_tdata;
        wr_ptr      <= ~wr_ptr;
        acc_cnt     <= acc_cnt + ONE;
      end
      if (slice_take) slice_cnt <= pop ? '0 : slice_cnt + SLICE_ONE;
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        pop_cnt <= pop_cnt + ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IFM_FEED_TLAST_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst || start_ok) err_q <= 1'b0;
    else if (push && (s_axis_tlast != (acc_cnt == len - ONE))) err_q <= 1'b1;
  end
  assign err_tlast = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_ifm_feed_ctrl.sv
// Self-checking bench for ifm_feed_ctrl: randomized beats against a slice-queue reference model.
module tb_ifm_feed_ctrl;
  localparam int IW = 512;
  localparam int OW = 64;
  localparam int S  = IW / OW;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst, conv_start;
  logic [LW-1:0] num_words;
  logic [IW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic [OW-1:0] fm_out;
  logic          fm_valid, fm_ready, busy, done, err_tlast;

  ifm_feed_ctrl #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .conv_start(conv_start), .num_words(num_words),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready), .fm_out(fm_out), .fm_valid(fm_valid),
    .fm_ready(fm_ready), .busy(busy), .done(done), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [IW-1:0] beats[$];
  bit            lasts[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  int beat_idx, n_acc, done_cnt, done_cyc, first_valid_cyc;
  logic s_tready, s_fm_valid, s_busy, s_done, s_err;
  logic [OW-1:0] s_fm_out;

`ifdef IFM_FEED_TLAST_CHECK_EN
  localparam logic TLAST_ERR_EXP = 1'b1;
`else
  localparam logic TLAST_ERR_EXP = 1'b0;
`endif

  // mode 0: byte-ramp pattern, mode 1: random data
  task automatic load_beats(input int n, input int offered, input int mode);
    logic [IW-1:0] b;
    beats.delete(); lasts.delete(); exp_q.delete(); got_q.delete();
    beat_idx = 0; n_acc = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    for (int i = 0; i < offered; i++) begin
      for (int w = 0; w < IW / 32; w++) b[w*32 +: 32] = $urandom();
      if (mode == 0)
        for (int j = 0; j < IW / 8; j++) b[j*8 +: 8] = 8'(i * (IW / 8) + j);
      beats.push_back(b);
      lasts.push_back(i == n - 1);
    end
  endtask

  // One clock cycle: drive inputs, sample away from the edge, update the model.
  task automatic tick(input logic fr);
    tvalid   = (beat_idx < beats.size());
    tdata    = tvalid ? beats[beat_idx] : '0;
    tlast    = tvalid ? lasts[beat_idx] : 1'b0;
    fm_ready = fr;
    #1;
    s_tready = tready; s_fm_valid = fm_valid; s_busy = busy;
    s_done = done; s_err = err_tlast; s_fm_out = fm_out;
    if (!rst) begin
      if (tvalid && tready) begin
        for (int k = 0; k < S; k++) exp_q.push_back(beats[beat_idx][k*OW +: OW]);
        beat_idx++;
        n_acc++;
      end
      if (fm_valid && fm_ready) got_q.push_back(fm_out);
      if (fm_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    @(posedge clk); #1;
    cyc++;
    conv_start = 1'b0;
  endtask

  task automatic start(input int n);
    conv_start = 1'b1;
    num_words  = LW'(n);
    tick(1'b1);
  endtask

  task automatic run_until_done(input int budget, input bit rnd, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget && timed_out; i++) begin
      tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (s_done) timed_out = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; conv_start = 1'b0; num_words = '0;
    tvalid = 1'b0; tdata = '0; tlast = 1'b0; fm_ready = 1'b0;
    load_beats(0, 0, 1);
    @(posedge clk); #1;
    tick(1'b0);
    vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready got %b want 0", s_tready); end
    vectors++; if (s_fm_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fm_valid got %b want 0", s_fm_valid); end
    vectors++; if (s_fm_out !== '0) begin miscompares++; $display("FAIL reset_fm_out got %h want 0", s_fm_out); end
    vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", s_busy); end
    vectors++; if (s_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", s_done); end
    vectors++; if (s_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", s_err); end
    rst = 1'b0;
    tick(1'b0);
    vectors++; if (s_busy !== 1'b0 || s_tready !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset busy=%b tready=%b want 0 0", s_busy, s_tready); end
  endtask

  task automatic test_basic();
    int t0; bit to; logic [OW-1:0] e;
    load_beats(2, 2, 0);
    t0 = cyc;
    start(2);
    tick(1'b1);
    vectors++; if (s_busy !== 1'b1 || s_tready !== 1'b1) begin miscompares++; $display("FAIL basic_t1 busy=%b tready=%b want 1 1", s_busy, s_tready); end
    vectors++; if (s_fm_valid !== 1'b0) begin miscompares++; $display("FAIL basic_t1_valid got %b want 0", s_fm_valid); end
    run_until_done(40, 1'b0, to);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout got no done want done"); end
    vectors++; if (first_valid_cyc != t0 + 2) begin miscompares++; $display("FAIL basic_first_valid got %0d want %0d", first_valid_cyc - t0, 2); end
    vectors++; if (done_cyc != t0 + 18) begin miscompares++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc - t0, 18); end
    vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done got %b want 0", s_busy); end
    vectors++; if (got_q.size() != 2 * S) begin miscompares++; $display("FAIL basic_count got %0d want %0d", got_q.size(), 2 * S); end
    for (int g = 0; g < got_q.size() && g < 2 * S; g++) begin
      for (int m = 0; m < OW / 8; m++) e[m*8 +: 8] = 8'(g * (OW / 8) + m);
      vectors++; if (got_q[g] !== e) begin miscompares++; $display("FAIL basic_slice%0d got %h want %h", g, got_q[g], e); end
    end
    tick(1'b1);
    vectors++; if (s_done !== 1'b0 || s_busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle done=%b busy=%b want 0 0", s_done, s_busy); end
  endtask

  task automatic test_backpressure();
    bit to; logic [OW-1:0] held; int guard;
    load_beats(3, 3, 1);
    start(3);
    guard = 0;
    while (got_q.size() < 4 && guard < 30) begin tick(1'b1); guard++; end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      if (i == 0) held = s_fm_out;
      vectors++; if (s_fm_valid !== 1'b1 || s_fm_out !== held) begin miscompares++; $display("FAIL bp_hold%0d valid=%b out=%h want 1 %h", i, s_fm_valid, s_fm_out, held); end
    end
    vectors++; if (s_tready !== 1'b0 || n_acc != 2) begin miscompares++; $display("FAIL bp_full tready=%b acc=%0d want 0 2", s_tready, n_acc); end
    run_until_done(300, 1'b1, to);
    vectors++; if (to) begin miscompares++; $display("FAIL bp_timeout got no done want done"); end
    vectors++; if (got_q.size() != exp_q.size() || exp_q.size() != 3 * S) begin miscompares++; $display("FAIL bp_count got %0d want %0d", got_q.size(), 3 * S); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_slice%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_length_bound();
    int viol; int pre; bit fin;
    load_beats(3, 5, 1);
    start(3);
    viol = 0; fin = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      pre = n_acc;
      tick(1'($urandom_range(0, 1)));
      if (pre == 3 && s_tready !== 1'b0) viol++;
      if (s_done) fin = 1;
    end
    vectors++; if (!fin) begin miscompares++; $display("FAIL len_timeout got no done want done"); end
    vectors++; if (n_acc != 3) begin miscompares++; $display("FAIL len_accepts got %0d want 3", n_acc); end
    vectors++; if (viol != 0) begin miscompares++; $display("FAIL len_tready_after_last got %0d high cycles want 0", viol); end
    vectors++; if (got_q.size() != 3 * S) begin miscompares++; $display("FAIL len_count got %0d want %0d", got_q.size(), 3 * S); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL len_slice%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    bit to;
    load_beats(0, 0, 1);
    start(0);
    tick(1'b1);
    vectors++; if (s_done !== 1'b1 || s_busy !== 1'b0 || s_tready !== 1'b0) begin miscompares++; $display("FAIL zero_t1 done=%b busy=%b tready=%b want 1 0 0", s_done, s_busy, s_tready); end
    tick(1'b1);
    vectors++; if (s_done !== 1'b0) begin miscompares++; $display("FAIL zero_t2_done got %b want 0", s_done); end
    load_beats(2, 2, 1);
    start(2);
    tick(1'b1); tick(1'b1);
    conv_start = 1'b1; num_words = LW'(5);
    tick(1'b1);
    run_until_done(100, 1'b1, to);
    vectors++; if (to) begin miscompares++; $display("FAIL ign_timeout got no done want done"); end
    vectors++; if (n_acc != 2 || done_cnt != 1) begin miscompares++; $display("FAIL ign_len acc=%0d done=%0d want 2 1", n_acc, done_cnt); end
    vectors++; if (got_q.size() != 2 * S) begin miscompares++; $display("FAIL ign_count got %0d want %0d", got_q.size(), 2 * S); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ign_slice%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    tick(1'b1); tick(1'b1);
    vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL ign_restart busy got %b want 0", s_busy); end
  endtask

  task automatic test_reset_mid_job();
    bit to; int guard;
    load_beats(4, 4, 1);
    start(4);
    guard = 0;
    while (got_q.size() < 5 && guard < 30) begin tick(1'b1); guard++; end
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    tick(1'b1);
    vectors++; if (s_fm_valid !== 1'b0 || s_tready !== 1'b0) begin miscompares++; $display("FAIL rstmid_hs valid=%b tready=%b want 0 0", s_fm_valid, s_tready); end
    vectors++; if (s_fm_out !== '0) begin miscompares++; $display("FAIL rstmid_fm_out got %h want 0", s_fm_out); end
    vectors++; if (s_busy !== 1'b0 || s_done !== 1'b0 || s_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_status busy=%b done=%b err=%b want 0 0 0", s_busy, s_done, s_err); end
    load_beats(1, 1, 1);
    start(1);
    run_until_done(60, 1'b1, to);
    vectors++; if (to || got_q.size() != S) begin miscompares++; $display("FAIL rstmid_job timeout=%b count=%0d want 0 %0d", to, got_q.size(), S); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_slice%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_tlast();
    int pre; int early; bit fin; bit to;
    load_beats(4, 4, 1);
    lasts[2] = 1'b1;
    lasts[3] = 1'b0;
    start(4);
    early = 0; fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      pre = n_acc;
      tick(1'b1);
      if (pre <= 2 && s_err !== 1'b0) early++;
      if (s_done) fin = 1;
    end
    vectors++; if (!fin) begin miscompares++; $display("FAIL tlast_timeout got no done want done"); end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL tlast_early got %0d cycles set want 0", early); end
    vectors++; if (s_err !== TLAST_ERR_EXP) begin miscompares++; $display("FAIL tlast_err got %b want %b", s_err, TLAST_ERR_EXP); end
    vectors++; if (got_q.size() != 4 * S) begin miscompares++; $display("FAIL tlast_count got %0d want %0d", got_q.size(), 4 * S); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL tlast_slice%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    tick(1'b1);
    vectors++; if (s_err !== TLAST_ERR_EXP) begin miscompares++; $display("FAIL tlast_sticky got %b want %b", s_err, TLAST_ERR_EXP); end
    load_beats(1, 1, 1);
    start(1);
    tick(1'b1);
    vectors++; if (s_err !== 1'b0) begin miscompares++; $display("FAIL tlast_clear got %b want 0", s_err); end
    run_until_done(60, 1'b0, to);
    vectors++; if (to || s_err !== 1'b0) begin miscompares++; $display("FAIL tlast_clean_job timeout=%b err=%b want 0 0", to, s_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_length_bound();
    test_zero_and_ignored_start();
    test_reset_mid_job();
    test_tlast();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
